mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, replacing the single-cycle multiply path in the ALU. Sits beside the ALU in the datapath. The control unit issues an operation with a start pulse and stalls the pipeline while `busy` is high. Supports signed/unsigned multiply and divide plus direct HI/LO writes; results are read from the `hi`/`lo` outputs (mfhi/mflo).

---
 rtl/mul_div_unit.sv | 100 ++++++++++
 tb/tb_mul_div_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed/unsigned multiply/divide with architectural HI/LO registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   mag_q, a_q, hi_q, lo_q, a_mag, b_mag, quo, rem, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               is_div_q, neg_q, rneg_q, bzero_q, done_q, divzero_q, a_neg, b_neg;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign divzero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    // operand magnitudes, one shift-add / restoring-divide step, and sign-corrected results
    always_comb begin
        a_neg    = ~op[0] & a[WIDTH-1];
        b_neg    = ~op[0] & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, mag_q};
        acc_d    = state_q == MUL ? {mul_sum, acc_q[WIDTH-1:1]} :
                   div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                                     {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod     = neg_q ? -acc_q : acc_q;
        quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_hi   = !is_div_q ? prod[2*WIDTH-1:WIDTH] : bzero_q ? a_q : rem;
        fix_lo   = !is_div_q ? prod[WIDTH-1:0] : bzero_q ? '1 : quo;
    end
    // control FSM: accept, iterate WIDTH times, commit HI/LO in FIX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            bzero_q   <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (op[2:1] == 2'b10) begin
                        if (op[0]) lo_q <= a;
                        else hi_q <= a;
                        done_q <= 1'b1;
                    end else if (!op[2]) begin
                        state_q  <= op[1] ? DIV : MUL;
                        is_div_q <= op[1];
                        cnt_q    <= CW'(WIDTH);
                        a_q      <= a;
                        bzero_q  <= b == '0;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        mag_q    <= op[1] ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    if (is_div_q) divzero_q <= bzero_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit at WIDTH=32 and WIDTH=8
module tb_mul_div_unit;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    logic s32, busy32, done32, dz32;
    logic [2:0] o32;
    logic [31:0] a32, b32, hi32, lo32;
    logic s8, busy8, done8, dz8;
    logic [2:0] o8;
    logic [7:0] a8, b8, hi8, lo8;
    int checks = 0, failures = 0;

    mul_div_unit #(.WIDTH(32)) d32 (.clk(clk), .reset(reset), .start(s32), .op(o32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .divzero(dz32), .hi(hi32), .lo(lo32));
    mul_div_unit #(.WIDTH(8)) d8 (.clk(clk), .reset(reset), .start(s8), .op(o8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .divzero(dz8), .hi(hi8), .lo(lo8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        int n = 0;
        @(negedge clk); s32 = 1'b1; o32 = op; a32 = a; b32 = b;
        @(negedge clk); s32 = 1'b0;
        while (busy32 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(done32), 64'd1);
        check({tag, "_hi"}, 64'(hi32), 64'(ehi));
        check({tag, "_lo"}, 64'(lo32), 64'(elo));
        @(negedge clk);
        check({tag, "_done_once"}, 64'(done32), 64'd0);
    endtask

    initial begin
        int n, dn;
        s32 = 0; o32 = 0; a32 = 0; b32 = 0;
        s8 = 0; o8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_dz", 64'(dz32), 64'd0);
        check("rst_hilo", {hi32, lo32}, 64'd0);
        reset = 1'b1;
        go32(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu");
        go32(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
        go32(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        go32(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu");
        check("divu_dz", 64'(dz32), 64'd0);
        go32(3'd2, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, "div0");
        check("div0_dz", 64'(dz32), 64'd1);
        go32(3'd0, 32'd5, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFE2, "mult_neg");
        check("mult_keeps_dz", 64'(dz32), 64'd1);
        go32(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "ovf");
        check("ovf_dz", 64'(dz32), 64'd0);
        // start during busy must be ignored
        @(negedge clk); s32 = 1'b1; o32 = 3'd1; a32 = 32'h10000; b32 = 32'h10000;
        @(negedge clk); s32 = 1'b0;
        repeat (4) @(negedge clk);
        s32 = 1'b1; o32 = 3'd4; a32 = 32'hDEADBEEF;
        @(negedge clk); s32 = 1'b0;
        @(negedge clk);
        check("ign_hilo_held", {hi32, lo32}, 64'h00000000_80000000);
        n = 0;
        while (busy32 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("ign_done", 64'(done32), 64'd1);
        check("ign_result", {hi32, lo32}, 64'h00000001_00000000);
        @(negedge clk);
        check("ign_no_mthi", 64'(hi32), 64'd1);
        // async reset mid-divide
        go32(3'd2, 32'h55, 32'd0, 32'h55, 32'hFFFFFFFF, "div0b");
        @(negedge clk); s32 = 1'b1; o32 = 3'd2; a32 = 32'd100; b32 = 32'd3;
        @(negedge clk); s32 = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(busy32), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("arst_flags", {61'd0, busy32, done32, dz32}, 64'd0);
        check("arst_hilo", {hi32, lo32}, 64'd0);
        @(negedge clk); reset = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || busy32) dn++;
        end
        check("arst_no_done", 64'(dn), 64'd0);
        go32(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "post_rst");
        // WIDTH=8: zero-stall MTLO, then MULTU
        @(negedge clk); s8 = 1'b1; o8 = 3'd5; a8 = 8'hA5;
        @(negedge clk); s8 = 1'b0;
        check("w8_mtlo_lo", 64'(lo8), 64'hA5);
        check("w8_mtlo_done", 64'(done8), 64'd1);
        check("w8_mtlo_busy", 64'(busy8), 64'd0);
        @(negedge clk);
        check("w8_mtlo_done_once", 64'(done8), 64'd0);
        @(negedge clk); s8 = 1'b1; o8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk); s8 = 1'b0;
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("w8_multu_lat", 64'(n), 64'd9);
        check("w8_multu_done", 64'(done8), 64'd1);
        check("w8_multu_res", {48'd0, hi8, lo8}, 64'hFE01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
